// File: rtl/bsync_trigger_scheduler.sv
// Multi-channel trigger scheduler aligned to the BSYNC/SYSREF period.
// Ports: clk, rst (sync, active-high), bsync_event/ready/ratio, trigger,
//   ch_en/mode/phase/burst in; trig_out, trig_state, busy out.
//   Optional (TRIGGER_FIRE_COUNT_EN): fire_count_clr in, fire_count out.
module bsync_trigger_scheduler #(
  parameter int CHANNEL_COUNT = 4,
  parameter int PHASE_WIDTH   = 16,
  parameter int BURST_WIDTH   = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               bsync_event,
  input  logic                               bsync_ready,
  input  logic [PHASE_WIDTH-1:0]             bsync_ratio,
  input  logic                               trigger,
  input  logic [CHANNEL_COUNT-1:0]           ch_en,
  input  logic [2*CHANNEL_COUNT-1:0]         ch_mode,
  input  logic [PHASE_WIDTH*CHANNEL_COUNT-1:0] ch_phase,
  input  logic [BURST_WIDTH*CHANNEL_COUNT-1:0] ch_burst,
`ifdef TRIGGER_FIRE_COUNT_EN
  input  logic                               fire_count_clr,
  output logic [16*CHANNEL_COUNT-1:0]        fire_count,
`endif
  output logic [CHANNEL_COUNT-1:0]           trig_out,
  output logic [3*CHANNEL_COUNT-1:0]         trig_state,
  output logic                               busy
);

  localparam int CC = CHANNEL_COUNT;
  localparam int PW = PHASE_WIDTH;
  localparam int BW = BURST_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_ARMED      = 3'd1,
    S_WAIT_BSYNC = 3'd2,
    S_WAIT_PHASE = 3'd3,
    S_ERR        = 3'd6
  } state_e;

  state_e          state_q [CC];
  state_e          state_d [CC];
  logic [1:0]      mode_q  [CC];
  logic [1:0]      mode_d  [CC];
  logic [PW-1:0]   phase_q [CC];
  logic [PW-1:0]   phase_d [CC];
  logic [BW-1:0]   rem_q   [CC];
  logic [BW-1:0]   rem_d   [CC];
  logic [CC-1:0]   trig_out_q;
  logic [CC-1:0]   trig_out_d;
  logic [PW-1:0]   phase_cnt_q;
  logic [PW-1:0]   phase_cnt_d;
  logic            trigger_q;
  logic            trigger_d;
  logic            eff_ready;
  logic            trig_edge;
  logic [CC-1:0]   fire;

  assign eff_ready = bsync_ready && (bsync_ratio != '0);
  assign trig_edge = trigger && !trigger_q;
  assign trigger_d = trigger;

  // phase_cnt_d is the phase position of the current cycle: 0 on the
  // bsync_event cycle itself, so a match here fires one cycle later.
  always_comb begin
    phase_cnt_d = phase_cnt_q + PW'(1);
    if (bsync_event)
      phase_cnt_d = '0;
    else if (phase_cnt_q == bsync_ratio - PW'(1))
      phase_cnt_d = '0;
  end

  always_comb begin
    for (int i = 0; i < CC; i++) begin
      state_d[i]    = state_q[i];
      mode_d[i]     = mode_q[i];
      phase_d[i]    = phase_q[i];
      rem_d[i]      = rem_q[i];
      fire[i]       = 1'b0;
      trig_out_d[i] = 1'b0;
      if (!ch_en[i]) begin
        state_d[i] = S_IDLE;
      end else begin
        case (state_q[i])
          S_IDLE: state_d[i] = S_ARMED;
          S_ARMED: begin
            if (trig_edge && eff_ready) begin
              state_d[i] = S_WAIT_BSYNC;
              mode_d[i]  = (ch_mode[2*i +: 2] == 2'd3) ?
                           2'd0 : ch_mode[2*i +: 2];
              phase_d[i] = ch_phase[PW*i +: PW];
              rem_d[i]   = (ch_burst[BW*i +: BW] == '0) ?
                           BW'(1) : ch_burst[BW*i +: BW];
            end
          end
          S_WAIT_BSYNC: begin
            if (!eff_ready) begin
              state_d[i] = S_ARMED;
              rem_d[i]   = '0;
            end else if (bsync_event) begin
              if (phase_q[i] >= bsync_ratio)
                state_d[i] = S_ERR;
              else if (phase_q[i] == '0)
                fire[i] = 1'b1;
              else
                state_d[i] = S_WAIT_PHASE;
            end
          end
          S_WAIT_PHASE: begin
            if (!eff_ready) begin
              state_d[i] = S_ARMED;
              rem_d[i]   = '0;
            end else if (phase_cnt_d == phase_q[i]) begin
              fire[i] = 1'b1;
            end else if (bsync_event) begin
              state_d[i] = S_ERR;
            end
          end
          S_ERR:   state_d[i] = S_ERR;
          default: state_d[i] = S_IDLE;
        endcase
        if (fire[i]) begin
          trig_out_d[i] = 1'b1;
          case (mode_q[i])
            2'd1: begin
              if (rem_q[i] <= BW'(1)) begin
                state_d[i] = S_ARMED;
                rem_d[i]   = '0;
              end else begin
                state_d[i] = S_WAIT_BSYNC;
                rem_d[i]   = rem_q[i] - BW'(1);
              end
            end
            2'd2:    state_d[i] = S_WAIT_BSYNC;
            default: state_d[i] = S_ARMED;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      trig_out_q  <= '0;
      phase_cnt_q <= '0;
      trigger_q   <= 1'b0;
      for (int i = 0; i < CC; i++) begin
        state_q[i] <= S_IDLE;
        mode_q[i]  <= '0;
        phase_q[i] <= '0;
        rem_q[i]   <= '0;
      end
    end else begin
      trig_out_q  <= trig_out_d;
      phase_cnt_q <= phase_cnt_d;
      trigger_q   <= trigger_d;
      for (int i = 0; i < CC; i++) begin
        state_q[i] <= state_d[i];
        mode_q[i]  <= mode_d[i];
        phase_q[i] <= phase_d[i];
        rem_q[i]   <= rem_d[i];
      end
    end
  end

  always_comb begin
    busy       = 1'b0;
    trig_state = '0;
    for (int i = 0; i < CC; i++) begin
      trig_state[3*i +: 3] = state_q[i];
      if (state_q[i] == S_WAIT_BSYNC || state_q[i] == S_WAIT_PHASE)
        busy = 1'b1;
    end
  end

  assign trig_out = trig_out_q;

`ifdef TRIGGER_FIRE_COUNT_EN
  logic [15:0] fcnt_q [CC];
  logic [15:0] fcnt_d [CC];

  // Clear wins over a coincident fire.
  always_comb begin
    for (int i = 0; i < CC; i++) begin
      fcnt_d[i] = fcnt_q[i];
      if (fire_count_clr)
        fcnt_d[i] = '0;
      else if (trig_out_d[i] && fcnt_q[i] != 16'hFFFF)
        fcnt_d[i] = fcnt_q[i] + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CC; i++) fcnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < CC; i++) fcnt_q[i] <= fcnt_d[i];
    end
  end

  always_comb begin
    fire_count = '0;
    for (int i = 0; i < CC; i++) fire_count[16*i +: 16] = fcnt_q[i];
  end
`endif

endmodule

// File: tb/tb_bsync_trigger_scheduler.sv
// Scoreboard bench for bsync_trigger_scheduler: expected pulses are
// queued by the stimulus and matched by a monitor on trig_out.
module tb_bsync_trigger_scheduler;

  localparam int CC = 4;
  localparam int PW = 16;
  localparam int BW = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              bsync_event;
  logic              bsync_ready;
  logic [PW-1:0]     bsync_ratio;
  logic              trigger;
  logic [CC-1:0]     ch_en;
  logic [2*CC-1:0]   ch_mode;
  logic [PW*CC-1:0]  ch_phase;
  logic [BW*CC-1:0]  ch_burst;
  logic [CC-1:0]     trig_out;
  logic [3*CC-1:0]   trig_state;
  logic              busy;
`ifdef TRIGGER_FIRE_COUNT_EN
  logic              fire_count_clr;
  logic [16*CC-1:0]  fire_count;
`endif

  bsync_trigger_scheduler #(
    .CHANNEL_COUNT(CC), .PHASE_WIDTH(PW), .BURST_WIDTH(BW)
  ) dut (
    .clk(clk), .rst(rst),
    .bsync_event(bsync_event), .bsync_ready(bsync_ready),
    .bsync_ratio(bsync_ratio), .trigger(trigger),
    .ch_en(ch_en), .ch_mode(ch_mode),
    .ch_phase(ch_phase), .ch_burst(ch_burst),
`ifdef TRIGGER_FIRE_COUNT_EN
    .fire_count_clr(fire_count_clr), .fire_count(fire_count),
`endif
    .trig_out(trig_out), .trig_state(trig_state), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    logic [3:0] mask;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  // Monitor: every nonzero trig_out must match the queue head.
  always @(negedge clk) begin
    if (trig_out != '0) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse cyc=%0d got=%b required=none",
                 cyc, trig_out);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (e.at != cyc || e.mask != trig_out) begin
          failures++;
          $display("FAIL pulse got cyc=%0d mask=%b required cyc=%0d mask=%b",
                   cyc, trig_out, e.at, e.mask);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic bs(output int t);
    bsync_event = 1'b1;
    t = cyc + 1;
    tick();
    bsync_event = 1'b0;
  endtask

  task automatic trig();
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
  endtask

  task automatic expect_pulse(input int at, input logic [3:0] m);
    exp_t e;
    e.at = at;
    e.mask = m;
    q.push_back(e);
  endtask

  task automatic set_ch(input int i, input logic [1:0] m,
                        input logic [PW-1:0] p, input logic [BW-1:0] b);
    ch_mode[2*i +: 2]   = m;
    ch_phase[PW*i +: PW] = p;
    ch_burst[BW*i +: BW] = b;
  endtask

  task automatic chk(input string n, input logic [31:0] got,
                     input logic [31:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s got=%0h required=%0h", n, got, req);
    end
  endtask

  function automatic logic [2:0] st(input int i);
    return trig_state[3*i +: 3];
  endfunction

  int t, t2, t3;

  initial begin
    rst = 1'b1;
    bsync_event = 1'b0;
    bsync_ready = 1'b1;
    bsync_ratio = 16'd100;
    trigger = 1'b0;
    ch_en = '0;
    ch_mode = '0;
    ch_phase = '0;
    ch_burst = '0;
`ifdef TRIGGER_FIRE_COUNT_EN
    fire_count_clr = 1'b0;
`endif
    ticks(3);
    chk("reset_state", {20'd0, trig_state}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_trig_out", {28'd0, trig_out}, 32'd0);
    rst = 1'b0;

    // One-shot, phase 10, ratio 100
    set_ch(0, 2'd0, 16'd10, 8'd0);
    ch_en = 4'b0001;
    tick();
    chk("arm_state", {29'd0, st(0)}, 32'd1);
    trig();
    chk("wait_bsync_state", {29'd0, st(0)}, 32'd2);
    chk("busy_wait", {31'd0, busy}, 32'd1);
    bs(t);
    expect_pulse(t + 10, 4'b0001);
    chk("wait_phase_state", {29'd0, st(0)}, 32'd3);
    ticks(99);
    repeat (4) begin
      bs(t2);
      ticks(99);
    end
    chk("oneshot_rearm", {29'd0, st(0)}, 32'd1);

    // Burst 3, phase 0, ratio 50
    bsync_ratio = 16'd50;
    set_ch(0, 2'd1, 16'd0, 8'd3);
    trig();
    bs(t);
    expect_pulse(t, 4'b0001);
    ticks(49);
    bs(t2);
    expect_pulse(t2, 4'b0001);
    ticks(49);
    bs(t3);
    expect_pulse(t3, 4'b0001);
    chk("burst_done", {29'd0, st(0)}, 32'd1);
    ticks(49);
    bs(t);
    ticks(5);

    // Burst length 0 behaves as 1
    set_ch(0, 2'd1, 16'd0, 8'd0);
    trig();
    bs(t);
    expect_pulse(t, 4'b0001);
    chk("burst0_done", {29'd0, st(0)}, 32'd1);
    ticks(49);
    bs(t);
    ticks(5);

    // ch0 one-shot + ch1 continuous, phase 49
    ch_en = 4'b0011;
    set_ch(0, 2'd0, 16'd49, 8'd0);
    set_ch(1, 2'd2, 16'd49, 8'd0);
    tick();
    chk("ch1_armed", {29'd0, st(1)}, 32'd1);
    trig();
    bs(t);
    expect_pulse(t + 49, 4'b0011);
    ticks(49);
    bs(t2);
    expect_pulse(t2 + 49, 4'b0010);
    ticks(49);
    bs(t2);
    chk("cont_ch0_state", {29'd0, st(0)}, 32'd1);
    chk("cont_ch1_state", {29'd0, st(1)}, 32'd3);
    ticks(20);
    ch_en = 4'b0001;
    tick();
    chk("cont_disable", {29'd0, st(1)}, 32'd0);
    ticks(40);

    // Phase beyond ratio -> ERR
    bsync_ratio = 16'd100;
    set_ch(0, 2'd0, 16'd120, 8'd0);
    trig();
    bs(t);
    chk("err_state", {29'd0, st(0)}, 32'd6);
    chk("err_busy", {31'd0, busy}, 32'd0);
    ticks(99);
    bs(t);
    chk("err_sticky", {29'd0, st(0)}, 32'd6);
    ch_en = 4'b0000;
    tick();
    chk("err_clear", {29'd0, st(0)}, 32'd0);
    ch_en = 4'b0001;
    tick();
    chk("err_rearm", {29'd0, st(0)}, 32'd1);

    // Trigger ignored without effective ready
    set_ch(0, 2'd0, 16'd5, 8'd0);
    bsync_ready = 1'b0;
    trig();
    chk("not_ready_ignore", {29'd0, st(0)}, 32'd1);
    bsync_ready = 1'b1;
    bsync_ratio = 16'd0;
    trig();
    chk("ratio0_ignore", {29'd0, st(0)}, 32'd1);
    bsync_ratio = 16'd100;
    tick();

    // Trigger edge coincident with bsync_event
    trigger = 1'b1;
    bsync_event = 1'b1;
    tick();
    trigger = 1'b0;
    bsync_event = 1'b0;
    chk("coincident_state", {29'd0, st(0)}, 32'd2);
    ticks(99);
    bs(t);
    expect_pulse(t + 5, 4'b0001);
    ticks(20);

    // bsync_ready drop during WAIT_PHASE
    set_ch(0, 2'd0, 16'd30, 8'd0);
    trig();
    bs(t);
    ticks(10);
    bsync_ready = 1'b0;
    tick();
    chk("ready_drop", {29'd0, st(0)}, 32'd1);
    bsync_ready = 1'b1;
    ticks(40);

    // Early bsync_event in WAIT_PHASE -> ERR
    trig();
    bs(t);
    ticks(10);
    bs(t);
    chk("early_bsync_err", {29'd0, st(0)}, 32'd6);
    ticks(40);
    ch_en = 4'b0000;
    tick();
    ch_en = 4'b0001;
    tick();

    // Reset in the middle of a burst
    bsync_ratio = 16'd50;
    set_ch(0, 2'd1, 16'd0, 8'd3);
    trig();
    bs(t);
    expect_pulse(t, 4'b0001);
    chk("burst_mid", {29'd0, st(0)}, 32'd2);
    ticks(10);
    rst = 1'b1;
    tick();
    chk("rst_state", {20'd0, trig_state}, 32'd0);
    chk("rst_trig_out", {28'd0, trig_out}, 32'd0);
    rst = 1'b0;
    ticks(38);
    bs(t);
    ticks(49);
    bs(t);
    ticks(5);
    chk("post_rst_armed", {29'd0, st(0)}, 32'd1);

`ifdef TRIGGER_FIRE_COUNT_EN
    fire_count_clr = 1'b1;
    tick();
    fire_count_clr = 1'b0;
    chk("fc_clr0", {16'd0, fire_count[15:0]}, 32'd0);
    trig();
    bs(t);
    expect_pulse(t, 4'b0001);
    ticks(49);
    bs(t);
    expect_pulse(t, 4'b0001);
    ticks(49);
    bs(t);
    expect_pulse(t, 4'b0001);
    tick();
    chk("fc_three", {16'd0, fire_count[15:0]}, 32'd3);
    fire_count_clr = 1'b1;
    tick();
    fire_count_clr = 1'b0;
    chk("fc_clr", {16'd0, fire_count[15:0]}, 32'd0);
`endif

    ticks(5);
    chk("queue_drained", q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
